// File: rtl/pipe_ctrl.sv
// Pipeline register write-control for the 5-stage core: stalls, flushes, multi-cycle ops.
// Optional performance counters (stall_cyc, flush_cyc) are built when PIPE_PERF_EN is defined.
module pipe_ctrl #(
   parameter int unsigned MC_LAT = 4,
   parameter int unsigned PERF_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              imem_busy,
   input  logic              dmem_busy,
   input  logic              load_use,
   input  logic              redirect,
   input  logic              mc_start,
   output logic [1:0]        FWrite,
   output logic [1:0]        DWrite,
   output logic [1:0]        EWrite,
   output logic [1:0]        MWrite,
   output logic [1:0]        WWrite
`ifdef PIPE_PERF_EN
   ,
   output logic [PERF_W-1:0] stall_cyc,
   output logic [PERF_W-1:0] flush_cyc
`endif
);

   localparam int unsigned CntW = $clog2(MC_LAT);

   localparam logic [1:0] Load  = 2'b00;
   localparam logic [1:0] Flush = 2'b01;
   localparam logic [1:0] Hold  = 2'b10;
   localparam logic [1:0] Mark  = 2'b11;

   typedef enum logic [1:0] {StRun, StMulti, StRedirWait} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] mc_cnt_q, mc_cnt_d;
   logic            redir_pend_q, redir_pend_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= StRun;
         mc_cnt_q     <= '0;
         redir_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mc_cnt_q     <= mc_cnt_d;
         redir_pend_q <= redir_pend_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      mc_cnt_d     = mc_cnt_q;
      redir_pend_d = redir_pend_q;
      FWrite       = Load;
      DWrite       = Load;
      EWrite       = Load;
      MWrite       = Load;
      WWrite       = Load;
      if (dmem_busy) begin
         FWrite       = Hold;
         DWrite       = Mark;
         EWrite       = Hold;
         MWrite       = Hold;
         WWrite       = Flush;
         redir_pend_d = redir_pend_q | redirect;
      end else if (state_q == StMulti) begin
         FWrite   = Hold;
         DWrite   = Mark;
         EWrite   = Hold;
         MWrite   = Flush;
         mc_cnt_d = mc_cnt_q - CntW'(1);
         if (mc_cnt_q == CntW'(1)) state_d = StRun;
      end else if (state_q == StRun && mc_start) begin
         FWrite   = Hold;
         DWrite   = Mark;
         EWrite   = Hold;
         MWrite   = Flush;
         mc_cnt_d = CntW'(MC_LAT - 1);
         state_d  = StMulti;
      end else if (redirect || redir_pend_q) begin
         // While the fetch is still busy, F holds and the stale word is dropped in REDIR_WAIT.
         FWrite       = imem_busy ? Hold : Load;
         DWrite       = Flush;
         EWrite       = Flush;
         redir_pend_d = 1'b0;
         state_d      = imem_busy ? StRedirWait : StRun;
      end else if (state_q == StRedirWait) begin
         FWrite = imem_busy ? Hold : Load;
         DWrite = Flush;
         if (!imem_busy) state_d = StRun;
      end else if (load_use) begin
         FWrite = Hold;
         DWrite = Mark;
         EWrite = Flush;
      end else if (imem_busy) begin
         FWrite = Hold;
         DWrite = Flush;
      end
      if (!resetn) begin
         FWrite = Flush;
         DWrite = Flush;
         EWrite = Flush;
         MWrite = Flush;
         WWrite = Flush;
      end
   end

`ifdef PIPE_PERF_EN
   logic stall_evt, flush_evt;

   assign stall_evt = FWrite[1] | DWrite[1] | EWrite[1] | MWrite[1] | WWrite[1];
   assign flush_evt = !dmem_busy && state_q != StMulti && !(state_q == StRun && mc_start)
                      && (redirect || redir_pend_q || state_q == StRedirWait);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cyc <= '0;
         flush_cyc <= '0;
      end else begin
         if (stall_evt && stall_cyc != '1) stall_cyc <= stall_cyc + PERF_W'(1);
         if (flush_evt && flush_cyc != '1) flush_cyc <= flush_cyc + PERF_W'(1);
      end
   end
`endif

   param_check: assert property (@(posedge clk) MC_LAT >= 2 && PERF_W >= 1);

   // The fetch redirect machinery can track only one outstanding redirect.
   no_redir_in_wait: assert property (@(posedge clk) disable iff (!resetn)
      !(state_q == StRedirWait && redirect));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; codes compared as packed {F,D,E,M,W}.
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       imem_busy = 1'b0;
   logic       dmem_busy = 1'b0;
   logic       load_use = 1'b0;
   logic       redirect = 1'b0;
   logic       mc_start = 1'b0;
   logic [1:0] FWrite, DWrite, EWrite, MWrite, WWrite;
`ifdef PIPE_PERF_EN
   logic [31:0] stall_cyc, flush_cyc;
`endif

   int checks = 0;
   int failures = 0;

   localparam logic [9:0] AllLd = 10'b00_00_00_00_00;
   localparam logic [9:0] LdUse = 10'b10_11_01_00_00;
   localparam logic [9:0] Multi = 10'b10_11_10_01_00;
   localparam logic [9:0] Rd0   = 10'b00_01_01_00_00;
   localparam logic [9:0] Rd1   = 10'b10_01_01_00_00;
   localparam logic [9:0] RwBsy = 10'b10_01_00_00_00;
   localparam logic [9:0] RwEnd = 10'b00_01_00_00_00;
   localparam logic [9:0] Dmem  = 10'b10_11_10_10_01;
   localparam logic [9:0] Ibsy  = 10'b10_01_00_00_00;
   localparam logic [9:0] Rst   = 10'b01_01_01_01_01;

   pipe_ctrl #(
      .MC_LAT (4),
      .PERF_W (32)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .imem_busy (imem_busy),
      .dmem_busy (dmem_busy),
      .load_use  (load_use),
      .redirect  (redirect),
      .mc_start  (mc_start),
      .FWrite    (FWrite),
      .DWrite    (DWrite),
      .EWrite    (EWrite),
      .MWrite    (MWrite),
      .WWrite    (WWrite)
`ifdef PIPE_PERF_EN
      ,
      .stall_cyc (stall_cyc),
      .flush_cyc (flush_cyc)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] codes();
      return {FWrite, DWrite, EWrite, MWrite, WWrite};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Apply inputs for one cycle (already #1 past posedge), check at negedge, advance.
   task automatic cyc(input string tag, input logic ib, input logic db, input logic lu,
                      input logic rd, input logic mc, input logic [9:0] exp);
      imem_busy = ib;
      dmem_busy = db;
      load_use  = lu;
      redirect  = rd;
      mc_start  = mc;
      @(negedge clk);
      check(tag, {22'd0, codes()}, {22'd0, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      imem_busy = 1'b0;
      dmem_busy = 1'b0;
      load_use  = 1'b0;
      redirect  = 1'b0;
      mc_start  = 1'b0;
      resetn    = 1'b0;
      #1;
      check("reset_async", {22'd0, codes()}, {22'd0, Rst});
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   initial begin
      #2;
      check("reset_hold", {22'd0, codes()}, {22'd0, Rst});
      @(posedge clk);
      #1;
      resetn = 1'b1;

      for (int i = 0; i < 10; i++) cyc("idle", 0, 0, 0, 0, 0, AllLd);

      cyc("load_use", 0, 0, 1, 0, 0, LdUse);
      cyc("after_lu", 0, 0, 0, 0, 0, AllLd);
      cyc("imem_busy", 1, 0, 0, 0, 0, Ibsy);

      // Multi-cycle op: 4 cycles of MULTI codes; load_use/imem_busy ignored meanwhile.
      cyc("mc_start", 0, 0, 0, 0, 1, Multi);
      cyc("multi_1", 0, 0, 1, 0, 0, Multi);
      cyc("multi_2", 1, 0, 0, 0, 0, Multi);
      cyc("multi_3", 0, 0, 0, 0, 0, Multi);
      cyc("multi_done", 0, 0, 0, 0, 0, AllLd);

      // Redirect during a fetch wait.
      cyc("redir_busy", 1, 0, 0, 1, 0, Rd1);
      cyc("rwait_1", 1, 0, 0, 0, 0, RwBsy);
      cyc("rwait_2", 1, 0, 1, 0, 0, RwBsy);
      cyc("rwait_end", 0, 0, 0, 0, 0, RwEnd);
      cyc("rwait_run", 0, 0, 0, 0, 0, AllLd);

      cyc("redir_free", 0, 0, 0, 1, 0, Rd0);
      cyc("redir_after", 0, 0, 0, 0, 0, AllLd);

      // dmem_busy freezes MULTI at mc_cnt=2.
      cyc("mc2_start", 0, 0, 0, 0, 1, Multi);
      cyc("mc2_m3", 0, 0, 0, 0, 0, Multi);
      cyc("dmem_1", 0, 1, 0, 0, 0, Dmem);
      cyc("dmem_2", 0, 1, 0, 0, 0, Dmem);
      cyc("mc2_m2", 0, 0, 0, 0, 0, Multi);
      cyc("mc2_m1", 0, 0, 0, 0, 0, Multi);
      cyc("mc2_done", 0, 0, 0, 0, 0, AllLd);

      // Redirect latched under dmem_busy, applied once it drops, then cleared.
      cyc("dmem_redir", 0, 1, 0, 1, 0, Dmem);
      cyc("dmem_hold", 0, 1, 0, 0, 0, Dmem);
      cyc("pend_apply", 0, 0, 0, 0, 0, Rd0);
      cyc("pend_clear", 0, 0, 0, 0, 0, AllLd);

      // Reset during REDIR_WAIT returns to RUN.
      cyc("rst_redir", 1, 0, 0, 1, 0, Rd1);
      cyc("rst_rwait", 1, 0, 0, 0, 0, RwBsy);
      pulse_reset();
      cyc("post_rst_rw", 0, 0, 0, 0, 0, AllLd);
`ifdef PIPE_PERF_EN
      check("stall_zero", stall_cyc, 32'd0);
      check("flush_zero", flush_cyc, 32'd0);
`endif

      // Reset with a latched redirect: nothing pending afterwards.
      cyc("rst_pend", 0, 1, 0, 1, 0, Dmem);
      pulse_reset();
      cyc("post_rst_pd", 0, 0, 0, 0, 0, AllLd);

      // Reset mid-MULTI.
      cyc("rst_mc", 0, 0, 0, 0, 1, Multi);
      pulse_reset();
      cyc("post_rst_mc", 0, 0, 0, 0, 0, AllLd);

`ifdef PIPE_PERF_EN
      cyc("perf_lu", 0, 0, 1, 0, 0, LdUse);
      cyc("perf_rd", 1, 0, 0, 1, 0, Rd1);
      cyc("perf_rw", 0, 0, 0, 0, 0, RwEnd);
      check("stall_cnt", stall_cyc, 32'd2);
      check("flush_cnt", flush_cyc, 32'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
